instr_decode_stage: RTL and testbench

- Registered, handshaked instruction decode stage; successor to the purely combinational control extractor.
- Decodes the RV32I opcode subset plus the FP load/store extension into datapath control.
- Holds one decoded instruction in an output register (valid/ready on both sides).
- Keeps a per-register load scoreboard for the integer and XMM files and stalls read-after-load and load-after-load hazards until writeback.

---
 rtl/instr_decode_stage.sv | 257 +++++++++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// Registered instruction decode stage with valid/ready handshake on both sides.
// Decodes RV32I plus FP load/store into datapath control and stalls on pending loads.
module instr_decode_stage #(
    parameter int INSTR_W    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 32,
    parameter bit ENABLE_XMM = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_W-1:0]    in_instr,
    input  logic [PC_W-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INSTR_W-1:0]    out_instr,
    output logic [PC_W-1:0]       out_pc,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [REG_ADDR_W-1:0] rs3_addr,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  should_read_mem,
    output logic                  should_write_mem,
    output logic                  should_write_reg,
    output logic                  should_write_xmm,
    output logic [2:0]            alu_a_src,
    output logic [2:0]            alu_b_src,
    output logic [2:0]            reg_write_src,
    output logic [2:0]            xmm_write_src,
    output logic [1:0]            mem_write_src,
    output logic                  illegal_op,
    input  logic                  wb_valid,
    input  logic                  wb_is_xmm,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr
);

    localparam int NREG = 2**REG_ADDR_W;

    localparam logic [4:0] OPC_LOAD   = 5'h00;
    localparam logic [4:0] OPC_FLOAD  = 5'h01;
    localparam logic [4:0] OPC_FENCE  = 5'h03;
    localparam logic [4:0] OPC_OPIMM  = 5'h04;
    localparam logic [4:0] OPC_AUIPC  = 5'h05;
    localparam logic [4:0] OPC_STORE  = 5'h08;
    localparam logic [4:0] OPC_FSTORE = 5'h09;
    localparam logic [4:0] OPC_OP     = 5'h0c;
    localparam logic [4:0] OPC_LUI    = 5'h0d;
    localparam logic [4:0] OPC_BRANCH = 5'h18;
    localparam logic [4:0] OPC_JALR   = 5'h19;
    localparam logic [4:0] OPC_JAL    = 5'h1b;

    localparam logic [2:0] SRC_ZERO  = 3'd0;
    localparam logic [2:0] SRC_PC4   = 3'd1;
    localparam logic [2:0] SRC_PC    = 3'd2;
    localparam logic [2:0] SRC_REG   = 3'd3;
    localparam logic [2:0] SRC_IMM12 = 3'd4;
    localparam logic [2:0] SRC_IMM20 = 3'd5;
    localparam logic [2:0] RWS_ALU   = 3'd2;
    localparam logic [2:0] RWS_MEM   = 3'd4;
    localparam logic [2:0] XWS_MEM   = 3'd4;
    localparam logic [1:0] MWS_REG   = 2'd1;
    localparam logic [1:0] MWS_XMM   = 2'd2;

    typedef struct packed {
        logic [INSTR_W-1:0]    instr;
        logic [PC_W-1:0]       pc;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rs3;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rd_mem;
        logic                  wr_mem;
        logic                  wr_reg;
        logic                  wr_xmm;
        logic [2:0]            a_src;
        logic [2:0]            b_src;
        logic [2:0]            rws;
        logic [2:0]            xws;
        logic [1:0]            mws;
        logic                  illegal;
    } entry_t;

    // Register fields are truncated or zero-extended to REG_ADDR_W.
    function automatic logic [REG_ADDR_W-1:0] reg_field(input logic [4:0] f);
        logic [REG_ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < REG_ADDR_W && i < 5; i++) begin
            r[i] = f[i];
        end
        return r;
    endfunction

    entry_t          dec;
    entry_t          ent_q, ent_d;
    logic            valid_q, valid_d;
    logic [4:0]      opc;
    logic            use_rs1, use_rs2, use_xs2, ld_int, ld_xmm;
    logic            hazard, accept;
    logic [NREG-1:0] sb_int_q, sb_int_d, sb_xmm_q, sb_xmm_d;
    logic [NREG-1:0] eff_int, eff_xmm, clr_int, clr_xmm, set_int, set_xmm;
    logic [NREG-1:0] wb_onehot, rd_onehot;

    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_xs2 = 1'b0;
        ld_int  = 1'b0;
        ld_xmm  = 1'b0;
        opc     = in_instr[6:2];
        dec.instr = in_instr;
        dec.pc    = in_pc;
        dec.rs1   = reg_field(in_instr[19:15]);
        dec.rs2   = reg_field(in_instr[24:20]);
        dec.rs3   = reg_field(in_instr[31:27]);
        dec.rd    = reg_field(in_instr[11:7]);
        if (in_instr[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            case (opc)
                OPC_LOAD: begin
                    dec.rd_mem = 1'b1;  dec.wr_reg = 1'b1;
                    dec.a_src  = SRC_REG; dec.b_src = SRC_IMM12; dec.rws = RWS_MEM;
                    use_rs1 = 1'b1; ld_int = 1'b1;
                end
                OPC_FLOAD: begin
                    if (ENABLE_XMM) begin
                        dec.rd_mem = 1'b1;  dec.wr_xmm = 1'b1;
                        dec.a_src  = SRC_REG; dec.b_src = SRC_IMM12; dec.xws = XWS_MEM;
                        use_rs1 = 1'b1; ld_xmm = 1'b1;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end
                OPC_FENCE: begin
                end
                OPC_OPIMM: begin
                    dec.wr_reg = 1'b1;
                    dec.a_src  = SRC_REG; dec.b_src = SRC_IMM12; dec.rws = RWS_ALU;
                    use_rs1 = 1'b1;
                end
                OPC_AUIPC: begin
                    dec.wr_reg = 1'b1;
                    dec.a_src  = SRC_PC; dec.b_src = SRC_IMM20; dec.rws = RWS_ALU;
                end
                OPC_STORE: begin
                    dec.wr_mem = 1'b1;
                    dec.a_src  = SRC_REG; dec.b_src = SRC_IMM12; dec.mws = MWS_REG;
                    use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OPC_FSTORE: begin
                    if (ENABLE_XMM) begin
                        dec.wr_mem = 1'b1;
                        dec.a_src  = SRC_REG; dec.b_src = SRC_IMM12; dec.mws = MWS_XMM;
                        use_rs1 = 1'b1; use_xs2 = 1'b1;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end
                OPC_OP: begin
                    dec.wr_reg = 1'b1;
                    dec.a_src  = SRC_REG; dec.b_src = SRC_REG; dec.rws = RWS_ALU;
                    use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OPC_LUI: begin
                    dec.wr_reg = 1'b1;
                    dec.a_src  = SRC_ZERO; dec.b_src = SRC_IMM20; dec.rws = RWS_ALU;
                end
                OPC_BRANCH: begin
                    dec.a_src = SRC_REG; dec.b_src = SRC_REG;
                    use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OPC_JALR: begin
                    dec.wr_reg = 1'b1;
                    dec.a_src  = SRC_PC4; dec.b_src = SRC_ZERO; dec.rws = RWS_ALU;
                    use_rs1 = 1'b1;
                end
                OPC_JAL: begin
                    dec.wr_reg = 1'b1;
                    dec.a_src  = SRC_PC4; dec.b_src = SRC_ZERO; dec.rws = RWS_ALU;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

    // Hazards look at the scoreboard after this cycle's writeback clear.
    assign wb_onehot = {{(NREG-1){1'b0}}, 1'b1} << wb_rd_addr;
    assign rd_onehot = {{(NREG-1){1'b0}}, 1'b1} << dec.rd;
    assign clr_int   = (wb_valid && !wb_is_xmm) ? wb_onehot : '0;
    assign clr_xmm   = (wb_valid &&  wb_is_xmm) ? wb_onehot : '0;
    assign eff_int   = sb_int_q & ~clr_int;
    assign eff_xmm   = sb_xmm_q & ~clr_xmm;

    assign hazard = (use_rs1 && eff_int[dec.rs1]) ||
                    (use_rs2 && eff_int[dec.rs2]) ||
                    (use_xs2 && eff_xmm[dec.rs2]) ||
                    (ld_int  && eff_int[dec.rd])  ||
                    (ld_xmm  && eff_xmm[dec.rd]);

    assign in_ready = !reset && (!valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    assign set_int = (accept && ld_int && dec.rd != '0) ? rd_onehot : '0;
    assign set_xmm = (accept && ld_xmm) ? rd_onehot : '0;

    always_comb begin
        sb_int_d    = eff_int | set_int;
        sb_int_d[0] = 1'b0;
        sb_xmm_d    = ENABLE_XMM ? (eff_xmm | set_xmm) : '0;
    end

    always_comb begin
        ent_d   = ent_q;
        valid_d = valid_q;
        if (accept) begin
            ent_d   = dec;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q    <= '0;
            valid_q  <= 1'b0;
            sb_int_q <= '0;
            sb_xmm_q <= '0;
        end else begin
            ent_q    <= ent_d;
            valid_q  <= valid_d;
            sb_int_q <= sb_int_d;
            sb_xmm_q <= sb_xmm_d;
        end
    end

    assign out_valid        = valid_q;
    assign out_instr        = ent_q.instr;
    assign out_pc           = ent_q.pc;
    assign rs1_addr         = ent_q.rs1;
    assign rs2_addr         = ent_q.rs2;
    assign rs3_addr         = ent_q.rs3;
    assign rd_addr          = ent_q.rd;
    assign should_read_mem  = ent_q.rd_mem;
    assign should_write_mem = ent_q.wr_mem;
    assign should_write_reg = ent_q.wr_reg;
    assign should_write_xmm = ent_q.wr_xmm;
    assign alu_a_src        = ent_q.a_src;
    assign alu_b_src        = ent_q.b_src;
    assign reg_write_src    = ent_q.rws;
    assign xmm_write_src    = ent_q.xws;
    assign mem_write_src    = ent_q.mws;
    assign illegal_op       = ent_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed scenarios plus random traffic against a
// pending-set reference model of the decode and scoreboard rules.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_instr, out_pc;
    logic [4:0]  rs1_addr, rs2_addr, rs3_addr, rd_addr, wb_rd_addr;
    logic        should_read_mem, should_write_mem, should_write_reg, should_write_xmm;
    logic [2:0]  alu_a_src, alu_b_src, reg_write_src, xmm_write_src;
    logic [1:0]  mem_write_src;
    logic        illegal_op, wb_valid, wb_is_xmm;

    logic        x_in_valid, x_in_ready, x_out_valid, x_out_ready;
    logic [31:0] x_in_instr, x_in_pc, x_out_instr, x_out_pc;
    logic [4:0]  x_rs1, x_rs2, x_rs3, x_rd;
    logic        x_rdm, x_wrm, x_wrr, x_wrx, x_ill;
    logic [2:0]  x_a, x_b, x_rws, x_xws;
    logic [1:0]  x_mws;

    instr_decode_stage #(.ENABLE_XMM(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs3_addr(rs3_addr), .rd_addr(rd_addr), .should_read_mem(should_read_mem),
        .should_write_mem(should_write_mem), .should_write_reg(should_write_reg),
        .should_write_xmm(should_write_xmm), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src),
        .reg_write_src(reg_write_src), .xmm_write_src(xmm_write_src),
        .mem_write_src(mem_write_src), .illegal_op(illegal_op), .wb_valid(wb_valid),
        .wb_is_xmm(wb_is_xmm), .wb_rd_addr(wb_rd_addr)
    );

    instr_decode_stage #(.ENABLE_XMM(1'b0)) dut_nx (
        .clk(clk), .reset(reset), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .in_instr(x_in_instr), .in_pc(x_in_pc), .out_valid(x_out_valid), .out_ready(x_out_ready),
        .out_instr(x_out_instr), .out_pc(x_out_pc), .rs1_addr(x_rs1), .rs2_addr(x_rs2),
        .rs3_addr(x_rs3), .rd_addr(x_rd), .should_read_mem(x_rdm),
        .should_write_mem(x_wrm), .should_write_reg(x_wrr),
        .should_write_xmm(x_wrx), .alu_a_src(x_a), .alu_b_src(x_b),
        .reg_write_src(x_rws), .xmm_write_src(x_xws),
        .mem_write_src(x_mws), .illegal_op(x_ill), .wb_valid(1'b0),
        .wb_is_xmm(1'b0), .wb_rd_addr(5'd0)
    );

    typedef struct packed {
        logic       rdm, wrm, wrr, wrx;
        logic [2:0] a, b, rws, xws;
        logic [1:0] mws;
        logic       ill;
    } ctl_t;

    ctl_t dut_ctl;
    assign dut_ctl = {should_read_mem, should_write_mem, should_write_reg, should_write_xmm,
                      alu_a_src, alu_b_src, reg_write_src, xmm_write_src, mem_write_src, illegal_op};

    int n_checks = 0;
    int n_errors = 0;

    bit        m_valid;
    bit [31:0] m_instr, m_pc, m_pint, m_pxmm;
    bit        last_rdy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Control expected from an instruction, written as membership of opcode groups.
    function automatic ctl_t ref_ctl(input logic [31:0] ins, input bit xmm_en);
        ctl_t       c;
        logic [4:0] op;
        bit         known;
        c  = '0;
        op = ins[6:2];
        known = (ins[1:0] == 2'b11) &&
                ((op inside {0, 3, 4, 5, 8, 12, 13, 24, 25, 27}) || (xmm_en && (op inside {1, 9})));
        if (!known) begin
            c.ill = 1'b1;
            return c;
        end
        c.rdm = op inside {0, 1};
        c.wrm = op inside {8, 9};
        c.wrr = op inside {0, 4, 5, 12, 13, 25, 27};
        c.wrx = (op == 1);
        if (op inside {0, 1, 4, 8, 9, 12, 24}) c.a = 3;
        else if (op == 5)                      c.a = 2;
        else if (op inside {25, 27})           c.a = 1;
        if (op inside {0, 1, 4, 8, 9})         c.b = 4;
        else if (op inside {5, 13})            c.b = 5;
        else if (op inside {12, 24})           c.b = 3;
        if (op == 0)                           c.rws = 4;
        else if (op inside {4, 5, 12, 13, 25, 27}) c.rws = 2;
        if (op == 1)                           c.xws = 4;
        if (op == 8)                           c.mws = 1;
        if (op == 9)                           c.mws = 2;
        return c;
    endfunction

    function automatic bit ref_hazard(input logic [31:0] ins, input bit [31:0] pi, input bit [31:0] px);
        logic [4:0] op, r1, r2, rd;
        bit         h;
        op = ins[6:2]; r1 = ins[19:15]; r2 = ins[24:20]; rd = ins[11:7];
        h  = 1'b0;
        pi[0] = 1'b0;
        if (ref_ctl(ins, 1'b1).ill) return 1'b0;
        if ((op inside {0, 1, 4, 8, 9, 12, 24, 25}) && pi[r1]) h = 1'b1;
        if ((op inside {8, 12, 24}) && pi[r2]) h = 1'b1;
        if (op == 9 && px[r2]) h = 1'b1;
        if (op == 0 && pi[rd]) h = 1'b1;
        if (op == 1 && px[rd]) h = 1'b1;
        return h;
    endfunction

    task automatic check_outputs();
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("out_instr", out_instr, m_instr);
            check("out_pc", out_pc, m_pc);
            check("addr", {rs1_addr, rs2_addr, rs3_addr, rd_addr},
                  {m_instr[19:15], m_instr[24:20], m_instr[31:27], m_instr[11:7]});
            check("ctl", dut_ctl, ref_ctl(m_instr, 1'b1));
        end
    endtask

    // One cycle: drive, compare against the model, advance the model across the edge.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit ordy,
                        input bit wbv, input bit wbx, input logic [4:0] wbrd);
        bit [31:0] ei, ex;
        bit        rdy;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy;
        wb_valid = wbv; wb_is_xmm = wbx; wb_rd_addr = wbrd;
        #1;
        ei = m_pint; ex = m_pxmm;
        if (wbv) begin
            if (wbx) ex[wbrd] = 1'b0;
            else     ei[wbrd] = 1'b0;
        end
        rdy = (!m_valid || ordy) && !ref_hazard(ins, ei, ex);
        check_outputs();
        check("in_ready", in_ready, rdy);
        last_rdy = in_ready;
        if (v && rdy) begin
            m_valid = 1'b1; m_instr = ins; m_pc = pc;
            if (!ref_ctl(ins, 1'b1).ill && ins[6:2] == 5'd0 && ins[11:7] != 5'd0) ei[ins[11:7]] = 1'b1;
            if (!ref_ctl(ins, 1'b1).ill && ins[6:2] == 5'd1) ex[ins[11:7]] = 1'b1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        m_pint = ei; m_pxmm = ex;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; in_valid = 1'b0; x_in_valid = 1'b0; wb_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            check("rst_in_ready", in_ready, 1'b0);
        end
        reset = 1'b0;
        in_instr = 32'h0000_0013;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_zero", {out_instr, out_pc, rs1_addr, rs2_addr, rs3_addr, rd_addr, dut_ctl}, '0);
        check("rst_ready_after", in_ready, 1'b1);
        check("rst_nx_valid", x_out_valid, 1'b0);
        m_valid = 1'b0; m_pint = '0; m_pxmm = '0;
    endtask

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_SW   = 32'h0011_2023;
    localparam logic [31:0] I_FSW  = 32'h0010_a027;
    localparam logic [31:0] I_LW5  = 32'h0000_a283;
    localparam logic [31:0] I_ADD  = 32'h0012_8333;
    localparam logic [31:0] I_NOP  = 32'h0000_0013;
    localparam logic [31:0] I_BAD  = 32'h0000_007f;
    localparam logic [31:0] I_FLW  = 32'h0000_a087;

    initial begin
        logic [31:0] nx_ins [3];
        bit          nx_ill [3];
        int          ops [14];
        logic [31:0] ins;
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_is_xmm = 1'b0; wb_rd_addr = '0;
        x_in_valid = 1'b0; x_in_instr = '0; x_in_pc = '0; x_out_ready = 1'b1;
        @(posedge clk); #1;
        do_reset(2);

        step(1, I_ADDI, 32'h100, 1, 0, 0, 0);
        check("addi_latency", out_instr, I_ADDI);
        step(1, I_SW, 32'h104, 1, 0, 0, 0);
        check("sw_mws", mem_write_src, 2'd1);
        step(1, I_FSW, 32'h108, 1, 0, 0, 0);
        check("fsw_mws", mem_write_src, 2'd2);
        check("fsw_b", alu_b_src, 3'd4);

        step(1, I_LW5, 32'h10c, 1, 0, 0, 0);
        step(1, I_ADD, 32'h110, 1, 0, 0, 0);
        check("raw_stall", last_rdy, 1'b0);
        step(1, I_ADD, 32'h110, 1, 0, 0, 0);
        step(1, I_ADD, 32'h110, 1, 1, 0, 5'd5);
        check("raw_bypass", last_rdy, 1'b1);
        check("add_accepted", out_instr, I_ADD);

        repeat (3) step(1, I_NOP, 32'h114, 0, 0, 0, 0);
        check("hold_ready", last_rdy, 1'b0);
        check("hold_instr", out_instr, I_ADD);
        step(1, I_NOP, 32'h114, 1, 0, 0, 0);
        check("release_accept", last_rdy, 1'b1);

        step(1, I_BAD, 32'h118, 1, 0, 0, 0);
        check("illegal_7f", illegal_op, 1'b1);
        step(1, I_NOP, 32'h11c, 1, 0, 0, 0);
        check("nop_legal", illegal_op, 1'b0);
        step(0, I_NOP, 32'h0, 1, 0, 0, 0);

        nx_ins = '{I_BAD, I_NOP, I_FLW};
        nx_ill = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            x_in_valid = 1'b1; x_in_instr = nx_ins[i]; x_in_pc = 32'(i * 4);
            @(posedge clk); #1;
            check("nx_valid", x_out_valid, 1'b1);
            check("nx_illegal", x_ill, nx_ill[i]);
        end
        x_in_valid = 1'b0;

        step(1, I_LW5, 32'h200, 1, 0, 0, 0);
        step(1, I_LW5, 32'h204, 1, 1, 0, 5'd5);
        check("waw_bypass_accept", last_rdy, 1'b1);
        step(1, I_ADD, 32'h208, 1, 0, 0, 0);
        check("set_wins", last_rdy, 1'b0);
        step(0, I_ADD, 32'h208, 0, 0, 0, 0);
        do_reset(1);
        step(1, I_ADD, 32'h20c, 1, 0, 0, 0);
        check("sb_cleared", last_rdy, 1'b1);

        ops = '{0, 1, 3, 4, 5, 8, 9, 12, 13, 24, 25, 27, 31, 2};
        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            ins[6:2]   = 5'(ops[$urandom_range(0, 13)]);
            ins[1:0]   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
